// File: rtl/sa_w_channel_arbiter_if.sv
// W-channel bundle between the master dispatchers, the slave AW arbiter and one slave W port.
// The slave modport is the arbiter's view; the master modport is the surrounding fabric's view.
interface sa_w_channel_arbiter_if #(
   parameter int unsigned MST_AMT    = 2,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MST_ID_W   = $clog2(MST_AMT)
);
   logic [DATA_WIDTH*MST_AMT-1:0] dsp_WDATA_i;
   logic [MST_AMT-1:0]            dsp_WLAST_i;
   logic [MST_AMT-1:0]            dsp_WVALID_i;
   logic [MST_AMT-1:0]            dsp_WDATA_sel_i;
   logic [MST_AMT-1:0]            dsp_WREADY_o;
   logic [MST_ID_W-1:0]           AW_mst_id_i;
   logic                          AW_hsk_i;
   logic                          AW_stall_o;
   logic [DATA_WIDTH-1:0]         s_WDATA_o;
   logic                          s_WLAST_o;
   logic                          s_WVALID_o;
   logic                          s_WREADY_i;

   modport slave (
      input  dsp_WDATA_i, dsp_WLAST_i, dsp_WVALID_i, dsp_WDATA_sel_i,
      input  AW_mst_id_i, AW_hsk_i, s_WREADY_i,
      output dsp_WREADY_o, AW_stall_o, s_WDATA_o, s_WLAST_o, s_WVALID_o
   );

   modport master (
      output dsp_WDATA_i, dsp_WLAST_i, dsp_WVALID_i, dsp_WDATA_sel_i,
      output AW_mst_id_i, AW_hsk_i, s_WREADY_i,
      input  dsp_WREADY_o, AW_stall_o, s_WDATA_o, s_WLAST_o, s_WVALID_o
   );
endinterface

// File: rtl/sa_w_channel_arbiter.sv
// Slave-side W arbiter: grants W bursts to masters strictly in AW acceptance order,
// using an in-order FIFO of master IDs and an IDLE/DATA sequencer.
module sa_w_channel_arbiter #(
   parameter int unsigned MST_AMT     = 2,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MST_ID_W    = $clog2(MST_AMT),
   parameter int unsigned ORDER_DEPTH = 4
) (
   input logic                  ACLK_i,
   input logic                  ARESETn_i,
   sa_w_channel_arbiter_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(ORDER_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {IDLE, DATA} state_t;

   state_t                state_q, state_d;
   logic [MST_ID_W-1:0]   cur_mst_q;
   logic [MST_ID_W-1:0]   order_mem [ORDER_DEPTH];
   logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic                  fifo_empty, fifo_full;
   logic                  push, pop, last_hsk;
   logic [DATA_WIDTH-1:0] owner_data;
   logic                  owner_valid, owner_sel, owner_last;

   assign fifo_empty     = (count_q == '0);
   assign fifo_full      = (count_q == CNT_W'(ORDER_DEPTH));
   assign bus.AW_stall_o = fifo_full;

   // Owner mux: everything forwarded comes from the master named by cur_mst_q.
   always_comb begin
      owner_data  = '0;
      owner_valid = 1'b0;
      owner_sel   = 1'b0;
      owner_last  = 1'b0;
      for (int unsigned m = 0; m < MST_AMT; m++) begin
         if (cur_mst_q == MST_ID_W'(m)) begin
            owner_data  = bus.dsp_WDATA_i[DATA_WIDTH*m +: DATA_WIDTH];
            owner_valid = bus.dsp_WVALID_i[m];
            owner_sel   = bus.dsp_WDATA_sel_i[m];
            owner_last  = bus.dsp_WLAST_i[m];
         end
      end
   end

   assign last_hsk = (state_q == DATA) & owner_valid & owner_sel & owner_last & bus.s_WREADY_i;
   assign pop      = !fifo_empty && ((state_q == IDLE) || last_hsk);
   // A push while full is only accepted when the head leaves in the same cycle.
   assign push     = bus.AW_hsk_i && (!fifo_full || pop);

   always_ff @(posedge ACLK_i) begin
      if (push) order_mem[wr_ptr_q] <= bus.AW_mst_id_i;
   end

   always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
      if (!ARESETn_i) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         cur_mst_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop) begin
            rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
            cur_mst_q <= order_mem[rd_ptr_q];
         end
         if (push && !pop)      count_q <= count_q + CNT_W'(1);
         else if (pop && !push) count_q <= count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
      if (!ARESETn_i) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!fifo_empty) state_d = DATA;
         DATA:    if (last_hsk && fifo_empty) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.s_WVALID_o   = 1'b0;
      bus.s_WDATA_o    = '0;
      bus.s_WLAST_o    = 1'b0;
      bus.dsp_WREADY_o = '0;
      if (state_q == DATA) begin
         bus.s_WVALID_o = owner_valid & owner_sel;
         bus.s_WDATA_o  = owner_data;
         bus.s_WLAST_o  = owner_last;
         for (int unsigned m = 0; m < MST_AMT; m++) begin
            if (cur_mst_q == MST_ID_W'(m)) bus.dsp_WREADY_o[m] = bus.s_WREADY_i & owner_sel;
         end
      end
   end
endmodule
